// File: rtl/fsm_scu.sv
// Checkpoint (save) control unit. It copies the register file into NVM, bracketed by
// a marker write that invalidates the image first and commits it with MAGIC last.
module fsm_scu #(
    parameter int                NREG       = 32,
    parameter int                CNT_W      = 5,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                BASE_ADDR  = 0,
    parameter int                VALID_ADDR = 32,
    parameter logic [DATA_W-1:0] MAGIC      = DATA_W'(32'hA5A5_5A5A)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Pwr_off,
    input  logic              SaveReq,
    input  logic              AckMem,
    input  logic [DATA_W-1:0] RegData,
    output logic [CNT_W-1:0]  RegSel,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              Busy,
    output logic              SaveDone
);

    // state  | meaning
    // IDLE   | waiting for a save request
    // INVAL  | writing 0 to the marker word so a partial image is never trusted
    // WRITE  | copying register cnt to NVM
    // COMMIT | writing MAGIC to the marker word
    // DONE   | image committed; waits for SaveReq to drop before re-arming
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INVAL  = 3'd1,
        WRITE  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] A_BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] A_VALID  = ADDR_W'(VALID_ADDR);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Power loss aborts exactly like reset; an image cut short keeps a zero marker.
    always_ff @(posedge Clk) begin
        if (Rst || Pwr_off) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (SaveReq) state <= INVAL;
                end
                INVAL: begin
                    if (AckMem) state <= WRITE;
                end
                WRITE: begin
                    if (AckMem) begin
                        if (cnt == CNT_LAST) begin
                            state <= COMMIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (AckMem) state <= DONE;
                end
                DONE: begin
                    if (!SaveReq) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        RegSel    = '0;
        MemWrEn   = 1'b0;
        MemAddr   = '0;
        MemWrData = '0;
        Busy      = 1'b0;
        SaveDone  = 1'b0;
        case (state)
            INVAL: begin
                MemWrEn = 1'b1;
                MemAddr = A_VALID;
                Busy    = 1'b1;
            end
            WRITE: begin
                MemWrEn   = 1'b1;
                RegSel    = cnt;
                MemAddr   = A_BASE + ADDR_W'(cnt);
                MemWrData = RegData;
                Busy      = 1'b1;
            end
            COMMIT: begin
                MemWrEn   = 1'b1;
                MemAddr   = A_VALID;
                MemWrData = MAGIC;
                Busy      = 1'b1;
            end
            DONE: begin
                SaveDone = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_scu.sv
// Bench for fsm_scu: single-cycle vector table followed by multi-cycle save scenarios
// against a small NVM model that logs every acknowledged write.
module tb_fsm_scu;

    localparam int          NREG    = 32;
    localparam logic [7:0]  A_VALID = 8'd32;
    localparam logic [31:0] MAGIC   = 32'hA5A5_5A5A;

    logic        Clk;
    logic        Rst;
    logic        Pwr_off;
    logic        SaveReq;
    logic        AckMem;
    logic [31:0] RegData;
    logic [4:0]  RegSel;
    logic        MemWrEn;
    logic [7:0]  MemAddr;
    logic [31:0] MemWrData;
    logic        Busy;
    logic        SaveDone;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] nvm [0:255];

    fsm_scu dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Pwr_off   (Pwr_off),
        .SaveReq   (SaveReq),
        .AckMem    (AckMem),
        .RegData   (RegData),
        .RegSel    (RegSel),
        .MemWrEn   (MemWrEn),
        .MemAddr   (MemAddr),
        .MemWrData (MemWrData),
        .Busy      (Busy),
        .SaveDone  (SaveDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Register file model: word i holds 0x1000 + i.
    assign RegData = 32'h1000 + 32'(RegSel);

    // NVM model: a write lands when acked, unless reset/power loss drops it.
    always @(posedge Clk) begin
        if (MemWrEn && AckMem && !Rst && !Pwr_off) begin
            nvm[MemAddr] = MemWrData;
            wa.push_back(MemAddr);
            wd.push_back(MemWrData);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        for (int i = 0; i < 256; i++) nvm[i] = 32'hFFFF_FFFF;
    endtask

    // Expected write order: marker 0, registers 0..NREG-1, marker MAGIC.
    task automatic check_image(input string tag, input int nexp);
        logic [7:0]  ea;
        logic [31:0] ed;
        chk({tag, "_count"}, 64'(wa.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wa.size(); i++) begin
            if (i == 0) begin
                ea = A_VALID; ed = 32'h0;
            end else if (i <= NREG) begin
                ea = 8'(i - 1); ed = 32'h1000 + 32'(i - 1);
            end else begin
                ea = A_VALID; ed = MAGIC;
            end
            chk($sformatf("%s_w%0d", tag, i), {24'h0, wa[i], wd[i]}, {24'h0, ea, ed});
        end
    endtask

    // Drives SaveReq and a responder on AckMem. Words 0..3 wait wfirst cycles
    // before their ack. pwr_at / drop_at fire on the WRITE of that register index;
    // rst_commit asserts Rst together with the ack of the COMMIT write.
    task automatic run_save(input int wfirst, input int pwr_at, input int drop_at,
                            input bit rst_commit, output int en_cycles,
                            output bit stable_ok, output bit finished);
        int          waited;
        int          words;
        int          wneed;
        bit          holding;
        logic [7:0]  ha;
        logic [31:0] hd;
        waited    = 0;
        words     = 0;
        holding   = 1'b0;
        ha        = '0;
        hd        = '0;
        en_cycles = 0;
        stable_ok = 1'b1;
        finished  = 1'b0;
        SaveReq   = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (SaveDone) begin
                finished = 1'b1;
                break;
            end
            if (MemWrEn) begin
                en_cycles++;
                if (holding && (MemAddr !== ha || MemWrData !== hd)) stable_ok = 1'b0;
                ha      = MemAddr;
                hd      = MemWrData;
                holding = 1'b1;
                if (pwr_at >= 0 && MemAddr == 8'(pwr_at)) begin
                    Pwr_off = 1'b1;
                    AckMem  = 1'b0;
                    SaveReq = 1'b0;
                    @(posedge Clk); #1;
                    Pwr_off = 1'b0;
                    return;
                end
                if (rst_commit && MemAddr == A_VALID && MemWrData == MAGIC) begin
                    Rst     = 1'b1;
                    AckMem  = 1'b1;
                    SaveReq = 1'b0;
                    @(posedge Clk); #1;
                    Rst    = 1'b0;
                    AckMem = 1'b0;
                    return;
                end
                if (drop_at >= 0 && MemAddr == 8'(drop_at)) SaveReq = 1'b0;
                wneed = (words < 4) ? wfirst : 0;
                if (waited >= wneed) begin
                    AckMem  = 1'b1;
                    waited  = 0;
                    words++;
                    holding = 1'b0;
                end else begin
                    AckMem = 1'b0;
                    waited++;
                end
            end else begin
                AckMem = 1'b0;
            end
            @(posedge Clk); #1;
        end
        AckMem = 1'b0;
    endtask

    typedef struct {
        logic        rst, pwr, req, ack;
        logic        en;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [4:0]  sel;
        logic        busy, done;
    } vec_t;

    vec_t vt[10];

    initial begin
        int en_cycles;
        bit stable_ok;
        bit finished;
        int done_cnt;
        int seen_done;

        Rst = 1'b0; Pwr_off = 1'b0; SaveReq = 1'b0; AckMem = 1'b0;
        clear_log();

        vt[0] = '{1,0,0,0, 0, 8'd0,  32'h0,    5'd0, 0, 0};
        vt[1] = '{0,0,0,1, 0, 8'd0,  32'h0,    5'd0, 0, 0};
        vt[2] = '{0,0,1,0, 1, 8'd32, 32'h0,    5'd0, 1, 0};
        vt[3] = '{0,0,1,0, 1, 8'd32, 32'h0,    5'd0, 1, 0};
        vt[4] = '{0,0,0,1, 1, 8'd0,  32'h1000, 5'd0, 1, 0};
        vt[5] = '{0,0,0,0, 1, 8'd0,  32'h1000, 5'd0, 1, 0};
        vt[6] = '{0,0,0,1, 1, 8'd1,  32'h1001, 5'd1, 1, 0};
        vt[7] = '{0,1,0,0, 0, 8'd0,  32'h0,    5'd0, 0, 0};
        vt[8] = '{0,0,1,0, 1, 8'd32, 32'h0,    5'd0, 1, 0};
        vt[9] = '{1,0,1,1, 0, 8'd0,  32'h0,    5'd0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            Rst = vt[i].rst; Pwr_off = vt[i].pwr; SaveReq = vt[i].req; AckMem = vt[i].ack;
            @(posedge Clk); #1;
            chk($sformatf("vec%0d", i),
                64'({MemWrEn, MemAddr, MemWrData, RegSel, Busy, SaveDone}),
                64'({vt[i].en, vt[i].addr, vt[i].data, vt[i].sel, vt[i].busy, vt[i].done}));
        end
        Rst = 1'b0; Pwr_off = 1'b0; SaveReq = 1'b0; AckMem = 1'b0;
        @(posedge Clk); #1;

        // Full save with zero-wait acks.
        clear_log();
        run_save(0, -1, -1, 1'b0, en_cycles, stable_ok, finished);
        chk("full_finished", 64'(finished), 64'd1);
        chk("full_en_cycles", 64'(en_cycles), 64'(NREG + 2));
        check_image("full", NREG + 2);
        chk("full_done_busy", 64'({SaveDone, Busy, MemWrEn}), 64'b100);

        // SaveReq held in DONE with spurious acks: no new writes.
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            AckMem = c[0];
            @(posedge Clk); #1;
            if (SaveDone && !Busy && !MemWrEn) done_cnt++;
        end
        AckMem = 1'b0;
        chk("hold_done_cycles", 64'(done_cnt), 64'd20);
        chk("hold_no_writes", 64'(wa.size()), 64'(NREG + 2));
        SaveReq = 1'b0;
        @(posedge Clk); #1;
        chk("rearm_idle", 64'({SaveDone, Busy, MemWrEn}), 64'b000);
        SaveReq = 1'b1;
        @(posedge Clk); #1;
        chk("rearm_inval", 64'({MemWrEn, Busy, MemAddr, MemWrData}), 64'({2'b11, A_VALID, 32'h0}));

        // Wait states on the first four words (save already in INVAL, no ack yet).
        clear_log();
        run_save(3, -1, -1, 1'b0, en_cycles, stable_ok, finished);
        chk("wait_finished", 64'(finished), 64'd1);
        chk("wait_stable", 64'(stable_ok), 64'd1);
        chk("wait_en_cycles", 64'(en_cycles), 64'(NREG + 2 + 12));
        check_image("wait", NREG + 2);
        SaveReq = 1'b0;
        @(posedge Clk); #1;

        // Power loss while register 10 is being written.
        clear_log();
        run_save(0, 10, -1, 1'b0, en_cycles, stable_ok, finished);
        chk("pwr_outputs", 64'({MemWrEn, Busy, SaveDone, MemAddr, RegSel}), 64'd0);
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            AckMem = 1'b1;
            @(posedge Clk); #1;
            if (SaveDone || MemWrEn) seen_done++;
        end
        AckMem = 1'b0;
        chk("pwr_quiet", 64'(seen_done), 64'd0);
        chk("pwr_marker", 64'(nvm[A_VALID]), 64'd0);
        check_image("pwr", 11);

        // SaveReq dropped mid-WRITE: save still completes, then returns to IDLE.
        clear_log();
        run_save(0, -1, 5, 1'b0, en_cycles, stable_ok, finished);
        chk("drop_finished", 64'(finished), 64'd1);
        chk("drop_en_cycles", 64'(en_cycles), 64'(NREG + 2));
        check_image("drop", NREG + 2);
        @(posedge Clk); #1;
        chk("drop_idle", 64'({SaveDone, Busy, MemWrEn}), 64'b000);

        // Rst in COMMIT together with its ack: reset wins.
        clear_log();
        run_save(0, -1, -1, 1'b1, en_cycles, stable_ok, finished);
        chk("rst_outputs", 64'({MemWrEn, Busy, SaveDone, MemAddr, MemWrData, RegSel}), 64'd0);
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            if (SaveDone) seen_done++;
        end
        chk("rst_never_done", 64'(seen_done), 64'd0);
        chk("rst_marker", 64'(nvm[A_VALID]), 64'd0);
        check_image("rst", NREG + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_scu.md
Name: fsm_scu

Overview:
- Save (checkpoint) control unit for the intermittent-computing core.
- On a low-voltage warning, copies every architectural register into non-volatile memory, bracketed by an invalidate/commit marker.
- Sits directly upstream of the restore control unit: it produces the NVM image that the restore unit reads back after power returns.
- The restore unit only trusts an image whose marker word equals MAGIC.

Parameters:
- NREG, 32, number of registers saved (indices 0..NREG-1); NREG >= 2.
- CNT_W, 5, width of register index counter; 2^CNT_W >= NREG.
- DATA_W, 32, register/memory word width.
- ADDR_W, 8, NVM word address width.
- BASE_ADDR, 0, NVM address of register 0.
- VALID_ADDR, 32, NVM address of the marker word; must lie outside BASE_ADDR..BASE_ADDR+NREG-1.
- MAGIC, 32'hA5A5_5A5A, marker value meaning image valid.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous, active-high.
- Pwr_off  in  1  power-loss abort, synchronous, active-high; same effect as Rst.
- SaveReq  in  1  low-voltage warning / save request, level.
- AckMem  in  1  NVM write acknowledge, one-cycle pulse.
- RegData  in  DATA_W  register file read data for index RegSel (combinational read).
- RegSel  out  CNT_W  register file read index.
- MemWrEn  out  1  NVM write request, held until AckMem.
- MemAddr  out  ADDR_W  NVM write address.
- MemWrData  out  DATA_W  NVM write data.
- Busy  out  1  save in progress.
- SaveDone  out  1  image committed.

Behaviour:
- Moore FSM, states IDLE, INVAL, WRITE, COMMIT, DONE; index counter Cnt (CNT_W bits).
- Outputs are combinational from State, Cnt and RegData. MemWrData passes RegData through in WRITE.
- Rst or Pwr_off at a rising Clk edge: State=IDLE, Cnt=0. Pwr_off has the same priority as Rst.
- Outputs in IDLE, and therefore after reset: MemWrEn=0, MemAddr=0, MemWrData=0, RegSel=0, Busy=0, SaveDone=0.
- IDLE: SaveReq=1 -> INVAL on the next edge, Cnt=0.
- INVAL: MemWrEn=1, MemAddr=VALID_ADDR, MemWrData=0, Busy=1.
  - AckMem=1 -> WRITE.
  - Otherwise hold.
- WRITE: MemWrEn=1, RegSel=Cnt, MemAddr=BASE_ADDR+Cnt (truncated to ADDR_W), MemWrData=RegData, Busy=1.
  - AckMem=1 and Cnt<NREG-1 -> Cnt+1, stay in WRITE.
  - AckMem=1 and Cnt==NREG-1 -> COMMIT, Cnt=0.
- COMMIT: MemWrEn=1, MemAddr=VALID_ADDR, MemWrData=MAGIC, Busy=1.
  - AckMem=1 -> DONE.
- DONE: SaveDone=1, Busy=0, MemWrEn=0.
  - SaveReq=0 -> IDLE.
  - Otherwise hold. No re-save until SaveReq is deasserted.
- Write latency: one request per word, no gap. A word completes in the cycle AckMem is seen; the next request is asserted in the following cycle.
- Total save for zero-wait ack = NREG+2 words.
- AckMem outside INVAL/WRITE/COMMIT: ignored.
- SaveReq deasserted during INVAL/WRITE/COMMIT: ignored; the save runs to completion.
- Pwr_off or Rst mid-save: immediate return to IDLE.
  - If this happens after the INVAL ack, the marker stays 0, so the image is invalid by construction.
  - An in-flight write is dropped: MemWrEn falls in the next cycle.
- Cnt never exceeds NREG-1; no wrap-around path exists.

Test Plan:
- Full save, NREG=32, AckMem 1 cycle after each request, RegData=0x1000+index -> writes in order:
  - [VALID_ADDR]=0
  - [0..31]=0x1000..0x101F
  - [VALID_ADDR]=0xA5A5_5A5A
  - then SaveDone=1 and Busy=0.
- Wait states: AckMem delayed 3 cycles on each of the first four words -> MemWrEn, MemAddr and MemWrData stay stable while waiting; no extra writes; final image identical to the full-save case.
- Pwr_off pulse while Cnt=10 in WRITE -> next cycle State=IDLE, MemWrEn=0, Busy=0; marker word remains 0; no commit write is issued.
- SaveReq held high through DONE for 20 cycles -> SaveDone stays 1 and no new writes occur. SaveReq=0 -> IDLE. SaveReq=1 again -> new INVAL write.
- Spurious AckMem in IDLE and DONE, plus SaveReq dropped mid-WRITE -> no state change from the spurious acks; the save still completes all NREG+2 writes.
- Rst asserted in COMMIT with AckMem=1 in the same cycle -> Rst wins: State=IDLE, SaveDone never asserted, all outputs 0 the next cycle.
